// File: rtl/hash_verifier.sv
// Receive-side byte-hash checker: recomputes a rotate/add hash one byte per clock and compares it to the attached hash.
// Optional saturating mismatch counter is compiled in when HASH_VERIFIER_MISMATCH_COUNT_EN is defined.
`timescale 1ns/1ps
module hash_verifier #(
  parameter int unsigned ROUND = 5,
  parameter logic [31:0] INIT  = 32'h1234_5678,
  parameter logic [31:0] K     = 32'h9E37_79B9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data,
  input  logic [3:0]  data_len,
  input  logic [31:0] expected_hash,
  output logic        done,
  output logic        match,
  output logic [31:0] computed_hash,
  output logic [7:0]  mismatch_count,
  output logic [1:0]  state_dbg
);

  // Handshake: a message is taken on any rising edge where in_valid && in_ready
  // (and reset is low); in_ready is high only in IDLE, so the sender holds in_valid
  // and its payload until it sees in_ready.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUND  = 2'd1,
    S_FINAL  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [3:0]  len_q, len_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] h_q, h_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] comp_q, comp_d;
  logic        match_q, match_d;

  logic [3:0]  len_clamped;
  logic [7:0]  cur_byte;
  logic [31:0] fin_hash;
  logic        last_byte;

  function automatic logic [31:0] rotl(input logic [31:0] x);
    return (x << ROUND) | (x >> (32 - ROUND));
  endfunction

  assign len_clamped = (data_len > 4'd8) ? 4'd8 : data_len;
  assign cur_byte    = data_q[{idx_q, 3'b000} +: 8];
  assign fin_hash    = rotl(h_q ^ {28'b0, len_q});
  assign last_byte   = ({1'b0, idx_q} == (len_q - 4'd1));

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    exp_d    = exp_q;
    h_d      = h_q;
    idx_d    = idx_q;
    comp_d   = comp_q;
    match_d  = match_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = data;
          len_d   = len_clamped;
          exp_d   = expected_hash;
          h_d     = INIT;
          idx_d   = 3'd0;
          state_d = (len_clamped == 4'd0) ? S_FINAL : S_ROUND;
        end
      end
      S_ROUND: begin
        h_d   = rotl(h_q ^ {24'b0, cur_byte}) + K;
        idx_d = idx_q + 3'd1;
        if (last_byte) state_d = S_FINAL;
      end
      S_FINAL: begin
        comp_d  = fin_hash;
        match_d = (fin_hash == exp_q);
        state_d = S_RESULT;
      end
      S_RESULT: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= 64'd0;
      len_q   <= 4'd0;
      exp_q   <= 32'd0;
      h_q     <= 32'd0;
      idx_q   <= 3'd0;
      comp_q  <= 32'd0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      h_q     <= h_d;
      idx_q   <= idx_d;
      comp_q  <= comp_d;
      match_q <= match_d;
    end
  end

  assign match         = match_q;
  assign computed_hash = comp_q;
  assign state_dbg     = state_q;

`ifdef HASH_VERIFIER_MISMATCH_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturates at 8'hFF; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_FINAL && fin_hash != exp_q && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign mismatch_count = cnt_q;
`else
  assign mismatch_count = 8'h00;
`endif

endmodule

// File: tb/tb_hash_verifier.sv
// Directed, table-driven bench for hash_verifier plus hand-written back-pressure and reset sequences.
`timescale 1ns/1ps
module tb_hash_verifier;
  localparam int unsigned ROUND = 5;
  localparam logic [31:0] INIT  = 32'h1234_5678;
  localparam logic [31:0] K     = 32'h9E37_79B9;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data;
  logic [3:0]  data_len;
  logic [31:0] expected_hash;
  logic        done;
  logic        match;
  logic [31:0] computed_hash;
  logic [7:0]  mismatch_count;
  logic [1:0]  state_dbg;

  hash_verifier #(.ROUND(ROUND), .INIT(INIT), .K(K)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data(data),
    .data_len(data_len),
    .expected_hash(expected_hash),
    .done(done),
    .match(match),
    .computed_hash(computed_hash),
    .mismatch_count(mismatch_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  len;
    logic [31:0] exp_hash;
    logic        exp_match;
    logic [31:0] exp_comp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] rl(input logic [31:0] x);
    return (x << ROUND) | (x >> (32 - ROUND));
  endfunction

  function automatic logic [31:0] model_hash(input logic [63:0] d, input logic [3:0] len);
    int          l;
    logic [31:0] h;
    l = (len > 4'd8) ? 8 : int'(len);
    h = INIT;
    for (int i = 0; i < l; i++) h = rl(h ^ {24'b0, d[8*i +: 8]}) + K;
    return rl(h ^ l);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic note_result(input logic m);
`ifdef HASH_VERIFIER_MISMATCH_COUNT_EN
    if (!m && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`else
    exp_cnt = 8'd0 & {8{m}};
`endif
  endtask

  // ---------------- driver ----------------
  task automatic run_msg(input logic [63:0] d, input logic [3:0] l, input logic [31:0] eh,
                         input logic exp_m, input logic [31:0] exp_c, input string tag,
                         input bit full, output logic [31:0] got);
    int lclamp;
    int lat;
    bit seen;
    lclamp = (l > 4'd8) ? 8 : int'(l);
    @(negedge clk);
    data = d; data_len = l; expected_hash = eh; in_valid = 1'b1;
    if (full) check({tag, "_ready_at_accept"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data = ~d; data_len = 4'd3; expected_hash = ~eh;
    lat = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (full) check({tag, "_busy_ready"}, in_ready, 0);
      if (done) seen = 1;
    end
    got = computed_hash;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=no_done required=done", tag);
    end else begin
      if (full) check({tag, "_latency"}, lat, lclamp + 2);
      check({tag, "_match"}, match, exp_m);
      check({tag, "_computed"}, computed_hash, exp_c);
      note_result(exp_m);
      check({tag, "_count"}, mismatch_count, exp_cnt);
      if (full) begin
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_ready_after"}, in_ready, 1);
        check({tag, "_match_held"}, match, exp_m);
        check({tag, "_computed_held"}, computed_hash, exp_c);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] full8;
    logic [7:0]  sat_exp;
    logic [31:0] bp_hash;
    bit          saw_done;

    reset = 1'b1; in_valid = 1'b0; data = 64'd0; data_len = 4'd0; expected_hash = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", in_ready, 1);
    check("reset_done", done, 0);
    check("reset_match", match, 0);
    check("reset_computed", computed_hash, 32'd0);
    check("reset_count", mismatch_count, 8'd0);
    check("reset_state", state_dbg, 2'd0);
    reset = 1'b0;

    vecs[0] = '{data: 64'hFFFF_FFFF_FFFF_FFFF, len: 4'd0, exp_hash: 32'h468A_CF02,
                exp_match: 1'b1, exp_comp: 32'h468A_CF02};
    vecs[1] = '{data: 64'hA5A5_A5A5_A5A5_A500, len: 4'd1, exp_hash: 32'h9849_175C,
                exp_match: 1'b1, exp_comp: 32'h9849_175C};
    vecs[2] = '{data: 64'h0000_0000_0000_0000, len: 4'd1, exp_hash: 32'h9849_175D,
                exp_match: 1'b0, exp_comp: 32'h9849_175C};
    full8 = model_hash(64'h0123_4567_89AB_CDEF, 4'd8);
    vecs[3] = '{data: 64'h0123_4567_89AB_CDEF, len: 4'd8, exp_hash: full8,
                exp_match: 1'b1, exp_comp: full8};
    vecs[4] = '{data: 64'h0123_4567_89AB_CDEF, len: 4'd15, exp_hash: full8,
                exp_match: 1'b1, exp_comp: full8};
    vecs[5] = '{data: 64'hDEAD_BEEF_CAFE_F00D, len: 4'd3,
                exp_hash: model_hash(64'hDEAD_BEEF_CAFE_F00D, 4'd3) ^ 32'h0000_0100,
                exp_match: 1'b0, exp_comp: model_hash(64'hDEAD_BEEF_CAFE_F00D, 4'd3)};
    vecs[6] = '{data: 64'h8000_0000_0000_0001, len: 4'd9,
                exp_hash: model_hash(64'h8000_0000_0000_0001, 4'd8),
                exp_match: 1'b1, exp_comp: model_hash(64'h8000_0000_0000_0001, 4'd8)};
    vecs[7] = '{data: 64'h5555_5555_0102_0304, len: 4'd4,
                exp_hash: model_hash(64'h0000_0000_0102_0304, 4'd4),
                exp_match: 1'b1, exp_comp: model_hash(64'h0000_0000_0102_0304, 4'd4)};

    for (int v = 0; v < 8; v++) begin
      run_msg(vecs[v].data, vecs[v].len, vecs[v].exp_hash, vecs[v].exp_match,
              vecs[v].exp_comp, $sformatf("vec%0d", v), 1'b1, got);
    end

    // Saturation: 300 more mismatching one-byte messages.
    for (int n = 0; n < 300; n++) begin
      run_msg(64'd0, 4'd1, 32'h9849_175D, 1'b0, 32'h9849_175C, "sat", 1'b0, got);
    end
`ifdef HASH_VERIFIER_MISMATCH_COUNT_EN
    sat_exp = 8'hFF;
`else
    sat_exp = 8'h00;
`endif
    check("sat_final_count", mismatch_count, sat_exp);

    // Back-pressure: in_valid held high with back-to-back L=2 messages.
    @(negedge clk);
    bp_hash = model_hash(64'h0000_0000_0000_3C7E, 4'd2);
    data = 64'h0000_0000_0000_3C7E; data_len = 4'd2; expected_hash = bp_hash; in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("bp_ready_c%0d", c), in_ready, ((c % 5) == 0) ? 1 : 0);
      check($sformatf("bp_done_c%0d", c), done, ((c % 5) == 4) ? 1 : 0);
      if (done) begin
        check("bp_computed", computed_hash, bp_hash);
        check("bp_match", match, 1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Mid-operation reset during the ROUND cycles of an L=8 message.
    data = 64'h0123_4567_89AB_CDEF; data_len = 4'd8; expected_hash = 32'h0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_in_round", state_dbg, 2'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 8'd0;
    check("midrst_ready", in_ready, 1);
    check("midrst_done", done, 0);
    check("midrst_match", match, 0);
    check("midrst_computed", computed_hash, 32'd0);
    check("midrst_count", mismatch_count, 8'd0);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("midrst_no_done", saw_done, 0);
    run_msg(vecs[3].data, vecs[3].len, vecs[3].exp_hash, 1'b1, full8, "post_rst", 1'b1, got);

    // Reset and in_valid on the same edge: nothing is accepted.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; data = 64'd0; data_len = 4'd0; expected_hash = 32'h468A_CF02;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("rstvalid_ready", in_ready, 1);
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("rstvalid_no_done", saw_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
